// File: rtl/sha256_nonce_select.sv
// sha256_nonce_select
// Scans the NUM_NONCES final hashes left in memory by the second-pass SHA-256
// stage, keeps the numerically smallest one (lowest nonce wins ties), compares
// it with the difficulty target and writes a status word followed by the
// winning hash to the result area.
//
// Memory layout read: nonce n, word w at input_addr + 8*n + w, h0 first.
// Memory layout written: status at result_addr, then h0..h7 at result_addr+1..8.
// All memory-port outputs are registered; their next values are derived from
// the next-state values so they line up with the state they belong to.

module sha256_nonce_select #(
  parameter int NUM_NONCES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  input_addr,
  input  logic [15:0]  result_addr,
  input  logic [255:0] target,
  output logic         done,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  output logic [31:0]  mem_write_data,
  input  logic [31:0]  mem_read_data
);

  // Index of the final nonce; counters are 8 bits wide to cover 1..256 nonces.
  localparam logic [7:0] LAST_NONCE = 8'(NUM_NONCES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CMP   = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Extract hash word idx (0 = h0, the most significant word) from a 256-bit hash.
  function automatic logic [31:0] hash_word(input logic [255:0] hash, input logic [2:0] idx);
    hash_word = hash[255 - 32*int'(idx) -: 32];
  endfunction

  // Status word: found flag in bit 31, winning nonce in bits 7:0.
  // found uses a strict unsigned compare, so a hash equal to the target fails.
  function automatic logic [31:0] status_word(input logic [255:0] best,
                                              input logic [255:0] tgt,
                                              input logic [7:0]   best_nonce);
    status_word = {(best < tgt), 23'd0, best_nonce};
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    nonce_r, nonce_s;
  logic [3:0]    j_r, j_s;
  logic [3:0]    k_r, k_s;
  logic [255:0]  hbuf_r, hbuf_s;
  logic [255:0]  best_r, best_s;
  logic [7:0]    best_nonce_r, best_nonce_s;
  logic [2:0]    rd_idx_s;
  logic          done_r, done_s;
  logic          mem_we_r, mem_we_s;
  logic [15:0]   mem_addr_r, mem_addr_s;
  logic [31:0]   mem_write_data_r, mem_write_data_s;

  assign mem_clk        = clk;
  assign done           = done_r;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_write_data = mem_write_data_r;

  // Word slot filled this READ cycle: data arriving at j belongs to address j-1
  // (j = 8 wraps the 3-bit result to slot 7).
  assign rd_idx_s = j_r[2:0] - 3'd1;

  // Next-state logic: sequencing, hash capture and running-minimum update.
  always_comb begin
    state_s      = state_r;
    nonce_s      = nonce_r;
    j_s          = j_r;
    k_s          = k_r;
    hbuf_s       = hbuf_r;
    best_s       = best_r;
    best_nonce_s = best_nonce_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          nonce_s = 8'd0;
          j_s     = 4'd0;
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (j_r != 4'd0) begin
          hbuf_s[255 - 32*int'(rd_idx_s) -: 32] = mem_read_data;
        end else begin
          hbuf_s = hbuf_r;
        end
        if (j_r == 4'd8) begin
          j_s     = 4'd0;
          state_s = CMP;
        end else begin
          j_s = j_r + 4'd1;
        end
      end
      CMP: begin
        // The first nonce always seeds the minimum; later ones must be strictly
        // smaller, which gives the lowest nonce priority on ties.
        if ((nonce_r == 8'd0) || (hbuf_r < best_r)) begin
          best_s       = hbuf_r;
          best_nonce_s = nonce_r;
        end else begin
          best_s       = best_r;
          best_nonce_s = best_nonce_r;
        end
        if (nonce_r == LAST_NONCE) begin
          k_s     = 4'd0;
          state_s = WRITE;
        end else begin
          nonce_s = nonce_r + 8'd1;
          j_s     = 4'd0;
          state_s = READ;
        end
      end
      WRITE: begin
        if (k_r == 4'd8) begin
          k_s     = 4'd0;
          state_s = IDLE;
        end else begin
          k_s = k_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next values of the registered memory-port outputs, taken from the next state.
  always_comb begin
    done_s           = 1'b0;
    mem_we_s         = 1'b0;
    mem_addr_s       = mem_addr_r;
    mem_write_data_s = 32'd0;
    case (state_s)
      IDLE: begin
        done_s = 1'b1;
      end
      READ: begin
        mem_addr_s = input_addr + {5'd0, nonce_s, 3'd0} + {12'd0, j_s};
      end
      CMP: begin
        mem_addr_s = mem_addr_r;
      end
      WRITE: begin
        mem_we_s   = 1'b1;
        mem_addr_s = result_addr + {12'd0, k_s};
        if (k_s == 4'd0) begin
          mem_write_data_s = status_word(best_s, target, best_nonce_s);
        end else begin
          mem_write_data_s = hash_word(best_s, k_s[2:0] - 3'd1);
        end
      end
      default: begin
        done_s = 1'b1;
      end
    endcase
  end

  // State, counters and hash registers; reset returns the block to IDLE at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      nonce_r      <= 8'd0;
      j_r          <= 4'd0;
      k_r          <= 4'd0;
      hbuf_r       <= 256'd0;
      best_r       <= 256'd0;
      best_nonce_r <= 8'd0;
    end else begin
      state_r      <= state_s;
      nonce_r      <= nonce_s;
      j_r          <= j_s;
      k_r          <= k_s;
      hbuf_r       <= hbuf_s;
      best_r       <= best_s;
      best_nonce_r <= best_nonce_s;
    end
  end

  // Registered outputs; reset drops mem_we immediately so no write can follow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_r           <= 1'b1;
      mem_we_r         <= 1'b0;
      mem_addr_r       <= 16'd0;
      mem_write_data_r <= 32'd0;
    end else begin
      done_r           <= done_s;
      mem_we_r         <= mem_we_s;
      mem_addr_r       <= mem_addr_s;
      mem_write_data_r <= mem_write_data_s;
    end
  end

endmodule

// File: tb/tb_sha256_nonce_select.sv
// Testbench for sha256_nonce_select: a table of scan scenarios with expected
// winner / found flag, a scoreboard queue of expected result-area writes, and
// hand-written reset-during-scan sequences.

module tb_sha256_nonce_select;

  localparam int NN      = 16;
  localparam int LATENCY = 10 * NN + 9;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [15:0]  input_addr;
  logic [15:0]  result_addr;
  logic [255:0] target;
  logic         done;
  logic         mem_clk;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic [31:0]  mem_read_data;

  logic [31:0]  mem [0:65535];

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int          pat;
    logic [1:0]  tsel;   // 0 all-ones, 1 zero, 2 = min hash, 3 = min hash + 1
    logic [15:0] ia;
    logic [15:0] ra;
    int          exp_nonce;
    logic        exp_found;
    bit          busy_start;
  } vec_t;

  wr_t  sb_q [$];
  vec_t vecs [8];
  int   n_vec;
  int   n_err;

  sha256_nonce_select #(.NUM_NONCES(NN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .input_addr     (input_addr),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data for the address presented appears next cycle.
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  // Hash word w of nonce n for each data pattern.
  function automatic logic [31:0] hword(input int pat, input int n, input int w);
    case (pat)
      0: hword = (n == 5) ? {8'h00, 8'(w), 16'h1234} : {8'(8'h40 + n), 8'(w), 16'hC0DE};
      1: hword = (n == 3 || n == 9) ? {16'h0001, 8'(w), 8'h77} : {8'h20, 8'(n), 8'(w), 8'h55};
      2: hword = (w < 7) ? (32'h0BAD_F00D + 32'(w)) : ((n == 12) ? 32'h0000_0007 : (32'h0000_0100 + 32'(n)));
      default: hword = 32'h1234_5678 + 32'(w);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_pat(input int pat, input logic [15:0] ia);
    for (int n = 0; n < NN; n++)
      for (int w = 0; w < 8; w++)
        mem[ia + 16'(8 * n + w)] = hword(pat, n, w);
  endtask

  // Run one scan with expected result writes queued on the scoreboard.
  task automatic run_vec(input vec_t v);
    logic [255:0] mh;
    int           cyc;
    bit           fin;
    wr_t          e;
    load_pat(v.pat, v.ia);
    for (int w = 0; w < 8; w++) mh[255 - 32*w -: 32] = hword(v.pat, v.exp_nonce, w);
    case (v.tsel)
      2'd0:    target = {256{1'b1}};
      2'd1:    target = 256'd0;
      2'd2:    target = mh;
      default: target = mh + 256'd1;
    endcase
    input_addr  = v.ia;
    result_addr = v.ra;
    sb_q.push_back({v.ra, {v.exp_found, 23'd0, 8'(v.exp_nonce)}});
    for (int w = 0; w < 8; w++) sb_q.push_back({v.ra + 16'(w + 1), hword(v.pat, v.exp_nonce, w)});
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    fin = 1'b0;
    for (int t = 0; t < 3000 && !fin; t++) begin
      @(negedge clk);
      start = (v.busy_start && (cyc == 40 || cyc == 100)) ? 1'b1 : 1'b0;
      if (mem_we) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_write", {16'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", {16'd0, mem_addr}, {16'd0, e.a});
          chk("wr_data", mem_write_data, e.d);
        end
        mem[mem_addr] = mem_write_data;
      end
      if (done) begin
        if (cyc > 0) fin = 1'b1;
      end else begin
        cyc++;
      end
    end
    start = 1'b0;
    chk("finished", 32'(fin), 32'd1);
    chk("latency", 32'(cyc), 32'(LATENCY));
    chk("writes_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Start a scan, pull reset at cycle at_cyc, check immediate effect.
  task automatic run_reset(input int at_cyc, input bit chk_mem);
    load_pat(0, 16'h0010);
    input_addr  = 16'h0010;
    result_addr = 16'h00B0;
    target      = {256{1'b1}};
    for (int k = 0; k < 9; k++) mem[16'h00B0 + 16'(k)] = 32'hDEAD_0000 + 32'(k);
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < at_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_we) begin
        if (chk_mem) chk("write_before_reset", {16'd0, mem_addr}, 32'hFFFF_FFFF);
        mem[mem_addr] = mem_write_data;
      end
    end
    chk("busy_before_reset", 32'(done), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("reset_done", 32'(done), 32'd1);
    chk("reset_we", 32'(mem_we), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_no_we", 32'(mem_we), 32'd0);
    end
    if (chk_mem) begin
      for (int k = 0; k < 9; k++)
        chk("result_untouched", mem[16'h00B0 + 16'(k)], 32'hDEAD_0000 + 32'(k));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    input_addr  = 16'h0000;
    result_addr = 16'h0000;
    target      = 256'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;

    vecs[0] = '{0, 2'd0, 16'h0010, 16'h00B0,  5, 1'b1, 1'b0};
    vecs[1] = '{0, 2'd1, 16'h0010, 16'h00B0,  5, 1'b0, 1'b0};
    vecs[2] = '{1, 2'd0, 16'h0010, 16'h00B0,  3, 1'b1, 1'b0};
    vecs[3] = '{2, 2'd0, 16'h0200, 16'h0300, 12, 1'b1, 1'b0};
    vecs[4] = '{2, 2'd2, 16'h0200, 16'h0300, 12, 1'b0, 1'b0};
    vecs[5] = '{2, 2'd3, 16'h0200, 16'h0300, 12, 1'b1, 1'b0};
    vecs[6] = '{0, 2'd0, 16'hFFF8, 16'hFFFC,  5, 1'b1, 1'b1};
    vecs[7] = '{3, 2'd0, 16'h0400, 16'h0500,  0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("mem_clk", 32'(mem_clk), 32'(clk));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of reading, then a clean full scan.
    run_reset(50, 1'b1);
    run_vec(vecs[0]);

    // Reset while the result area is being written, then a clean full scan.
    run_reset(LATENCY - 4, 1'b0);
    run_vec(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
